reg_scoreboard: RTL and testbench

Parametrised register scoreboard for the decode stage. It replaces the single-bit per-register busy flags with a per-register pending-write counter and supports multiple writeback ports. It raises a combinational stall to the decode stage when a source operand has an outstanding write, or when a destination's pending counter is saturated. It sits between the instruction decoder, which issues requests, and the writeback stage, which retires writes.

---
 rtl/reg_scoreboard_pkg.sv | 14 +
 rtl/reg_scoreboard_if.sv | 38 +++
 rtl/reg_scoreboard_entry.sv | 46 ++++
 rtl/reg_scoreboard.sv | 102 ++++++++++
 tb/tb_reg_scoreboard.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared defaults, counter-width helper and address type for the register scoreboard.
package scoreboard_pkg;

    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_MAX_PEND = 3;
    localparam int unsigned DEF_NUM_WB   = 2;

    function automatic int unsigned cnt_w(input int unsigned max_pend);
        return $clog2(max_pend + 1);
    endfunction

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-side request/stall and writeback retire bundle of the register scoreboard.
interface reg_scoreboard_if
    import scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_WB = DEF_NUM_WB
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic                     id_valid;
    logic [ADDR_W-1:0]        id_src1;
    logic [ADDR_W-1:0]        id_src2;
    logic                     id_src1_en;
    logic                     id_src2_en;
    logic [ADDR_W-1:0]        id_dst;
    logic                     id_dst_en;
    logic                     id_stall;
    logic                     id_fire;
    logic [NUM_WB-1:0]        wb_en;
    logic [NUM_WB*ADDR_W-1:0] wb_addr;
    logic                     flush;
    logic [NUM_REGS-1:0]      busy_vec;
    logic                     err_underflow;

    modport master (
        output id_valid, id_src1, id_src2, id_src1_en, id_src2_en, id_dst, id_dst_en,
        output wb_en, wb_addr, flush,
        input  id_stall, id_fire, busy_vec, err_underflow
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_src1_en, id_src2_en, id_dst, id_dst_en,
        input  wb_en, wb_addr, flush,
        output id_stall, id_fire, busy_vec, err_underflow
    );

endinterface

// File: rtl/reg_scoreboard_entry.sv
// One per-register pending-write counter (module sb_entry); saturates to 0 on underflow.
module sb_entry
    import scoreboard_pkg::*;
#(
    parameter int unsigned MAX_PEND = DEF_MAX_PEND,
    parameter int unsigned NUM_WB   = DEF_NUM_WB,
    localparam int unsigned CNT_W   = cnt_w(MAX_PEND),
    localparam int unsigned DEC_W   = $clog2(NUM_WB + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             nz,
    output logic             underflow
);

    localparam int unsigned SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] total, dec_x;

    always_comb begin
        total     = SUM_W'(cnt_q) + SUM_W'(inc);
        dec_x     = SUM_W'(dec);
        underflow = dec_x > total;
        cnt_d     = underflow ? '0 : CNT_W'(total - dec_x);
        if (flush) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign nz  = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Multi-port pending-write register scoreboard with combinational decode stall.
// Optional same-cycle writeback bypass of the stall checks: SCOREBOARD_BYPASS_EN.
module reg_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned MAX_PEND = DEF_MAX_PEND,
    parameter int unsigned NUM_WB   = DEF_NUM_WB
) (
    input logic             clk,
    input logic             reset,
    reg_scoreboard_if.slave sb
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned CNT_W    = cnt_w(MAX_PEND);
    localparam int unsigned DEC_W    = $clog2(NUM_WB + 1);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:1]            nz;
    logic [NUM_REGS-1:1]            uf;
    logic                           src1_busy, src2_busy, dst_full;
    logic                           err_q;

    assign cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic             inc;
        logic [DEC_W-1:0] dec;

        always_comb begin
            dec = '0;
            for (int k = 0; k < NUM_WB; k++) begin
                if (sb.wb_en[k] && (sb.wb_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    dec = dec + DEC_W'(1);
                end
            end
        end

        assign inc = sb.id_fire && sb.id_dst_en && (sb.id_dst == ADDR_W'(r));

        sb_entry #(
            .MAX_PEND (MAX_PEND),
            .NUM_WB   (NUM_WB)
        ) u_entry (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc),
            .dec       (dec),
            .flush     (sb.flush),
            .cnt       (cnt[r]),
            .nz        (nz[r]),
            .underflow (uf[r])
        );
    end

`ifdef SCOREBOARD_BYPASS_EN
    function automatic logic [DEC_W-1:0] dec_of(input logic [ADDR_W-1:0] a);
        logic [DEC_W-1:0] d;
        d = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (sb.wb_en[k] && (sb.wb_addr[k*ADDR_W +: ADDR_W] == a)) begin
                d = d + DEC_W'(1);
            end
        end
        return d;
    endfunction

    // Pending writes that retire this cycle are forwarded, so they no longer block.
    always_comb begin
        src1_busy = sb.id_src1_en && (sb.id_src1 != '0) &&
                    (32'(cnt[sb.id_src1]) > 32'(dec_of(sb.id_src1)));
        src2_busy = sb.id_src2_en && (sb.id_src2 != '0) &&
                    (32'(cnt[sb.id_src2]) > 32'(dec_of(sb.id_src2)));
        dst_full  = sb.id_dst_en && (sb.id_dst != '0) &&
                    (32'(cnt[sb.id_dst]) == 32'(MAX_PEND) + 32'(dec_of(sb.id_dst)));
    end
`else
    always_comb begin
        src1_busy = sb.id_src1_en && (sb.id_src1 != '0) && (cnt[sb.id_src1] != '0);
        src2_busy = sb.id_src2_en && (sb.id_src2 != '0) && (cnt[sb.id_src2] != '0);
        dst_full  = sb.id_dst_en && (sb.id_dst != '0) &&
                    (32'(cnt[sb.id_dst]) == 32'(MAX_PEND));
    end
`endif

    assign sb.id_stall = sb.id_valid && (src1_busy || src2_busy || dst_full);
    assign sb.id_fire  = sb.id_valid && !sb.id_stall && !sb.flush;

    // Sticky; a flush cycle never records an underflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (!sb.flush && (|uf)) begin
            err_q <= 1'b1;
        end
    end

    assign sb.busy_vec      = {nz, 1'b0};
    assign sb.err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed plus randomized bench for reg_scoreboard against a pending-count reference model.
module tb_reg_scoreboard;
    import scoreboard_pkg::*;

    localparam int MAXP = 3;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    int   cnt_m [32];
    bit   err_m;

    reg_scoreboard_if #(.ADDR_W(5), .NUM_WB(2)) sbif ();

    reg_scoreboard #(
        .ADDR_W   (5),
        .MAX_PEND (MAXP),
        .NUM_WB   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int s1, input bit e1, input int s2, input bit e2,
                         input int d, input bit de, input bit [1:0] wbe, input int a0,
                         input int a1, input bit fl);
        sbif.id_valid   = v;
        sbif.id_src1    = reg_addr_t'(s1);
        sbif.id_src1_en = e1;
        sbif.id_src2    = reg_addr_t'(s2);
        sbif.id_src2_en = e2;
        sbif.id_dst     = reg_addr_t'(d);
        sbif.id_dst_en  = de;
        sbif.wb_en      = wbe;
        sbif.wb_addr    = {reg_addr_t'(a1), reg_addr_t'(a0)};
        sbif.flush      = fl;
    endtask

    function automatic bit [31:0] busy_exp();
        bit [31:0] b;
        b = '0;
        for (int r = 1; r < 32; r++) b[r] = (cnt_m[r] != 0);
        return b;
    endfunction

    function automatic int retires(input int a);
        int n;
        n = 0;
        if (sbif.wb_en[0] && (int'(sbif.wb_addr[4:0]) == a)) n++;
        if (sbif.wb_en[1] && (int'(sbif.wb_addr[9:5]) == a)) n++;
        return n;
    endfunction

    function automatic bit src_blocks(input bit en, input int a);
`ifdef SCOREBOARD_BYPASS_EN
        return en && (a != 0) && (cnt_m[a] - retires(a) > 0);
`else
        return en && (a != 0) && (cnt_m[a] != 0);
`endif
    endfunction

    function automatic bit dst_blocks(input bit en, input int a);
`ifdef SCOREBOARD_BYPASS_EN
        return en && (a != 0) && (cnt_m[a] - retires(a) == MAXP);
`else
        return en && (a != 0) && (cnt_m[a] == MAXP);
`endif
    endfunction

    // One clock: check combinational outputs mid-cycle, then advance the model at the edge.
    task automatic cycle(input string tag);
        bit stall_e, fire_e;
        int nxt;
        @(negedge clk);
        stall_e = sbif.id_valid &&
                  (src_blocks(sbif.id_src1_en, int'(sbif.id_src1)) ||
                   src_blocks(sbif.id_src2_en, int'(sbif.id_src2)) ||
                   dst_blocks(sbif.id_dst_en, int'(sbif.id_dst)));
        fire_e  = sbif.id_valid && !stall_e && !sbif.flush;
        chk(32'(sbif.id_stall), 32'(stall_e), {tag, ".stall"});
        chk(32'(sbif.id_fire), 32'(fire_e), {tag, ".fire"});
        chk(sbif.busy_vec, busy_exp(), {tag, ".busy"});
        chk(32'(sbif.err_underflow), 32'(err_m), {tag, ".err"});
        @(posedge clk);
        if (sbif.flush) begin
            for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                nxt = cnt_m[r] - retires(r);
                if (fire_e && sbif.id_dst_en && (int'(sbif.id_dst) == r)) nxt++;
                if (nxt < 0) begin
                    nxt   = 0;
                    err_m = 1'b1;
                end
                cnt_m[r] = nxt;
            end
        end
        #1;
    endtask

    function automatic int pick_pending();
        int r;
        r = $urandom_range(1, 7);
        for (int t = 0; t < 8; t++) begin
            if (cnt_m[r] != 0) return r;
            r = $urandom_range(1, 7);
        end
        return r;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        err_m    = 1'b0;
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        #12;
        chk(32'(sbif.id_stall), 32'd0, "rst.stall");
        chk(32'(sbif.id_fire), 32'd0, "rst.fire");
        chk(sbif.busy_vec, 32'd0, "rst.busy");
        chk(32'(sbif.err_underflow), 32'd0, "rst.err");
        reset = 1'b0;
        @(posedge clk);
        #1;

        drive(1, 3, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);  cycle("src3");
        drive(1, 0, 0, 0, 0, 5, 1, 2'b00, 0, 0, 0);  cycle("iss5");
        drive(1, 5, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);  cycle("raw5");
        drive(0, 0, 0, 0, 0, 0, 0, 2'b01, 5, 0, 0);  cycle("wb5");
        drive(1, 5, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);  cycle("raw5clr");
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 7, 1, 2'b00, 0, 0, 0);  cycle("iss7");
        end
        drive(1, 0, 0, 0, 0, 7, 1, 2'b00, 0, 0, 0);  cycle("sat7");
        drive(1, 0, 0, 0, 0, 7, 1, 2'b11, 7, 7, 0);  cycle("sat7wb");
        drive(1, 0, 0, 7, 1, 0, 0, 2'b00, 0, 0, 0);  cycle("cnt7one");
        drive(0, 0, 0, 0, 0, 0, 0, 2'b01, 7, 0, 0);  cycle("wb7");
        drive(1, 0, 0, 0, 0, 4, 1, 2'b00, 0, 0, 0);  cycle("iss4");
        drive(1, 0, 0, 0, 0, 4, 1, 2'b10, 0, 4, 0);  cycle("iss4wb4");
        drive(1, 4, 1, 0, 0, 0, 0, 2'b01, 9, 0, 0);  cycle("uf9");
        drive(0, 0, 0, 0, 0, 0, 0, 2'b01, 4, 0, 0);  cycle("wb4");
        drive(1, 0, 1, 0, 1, 0, 1, 2'b01, 0, 0, 0);  cycle("zero");
        drive(1, 0, 0, 0, 0, 2, 1, 2'b00, 0, 0, 0);  cycle("iss2a");
        drive(1, 0, 0, 0, 0, 2, 1, 2'b00, 0, 0, 0);  cycle("iss2b");
        drive(1, 0, 0, 0, 0, 2, 1, 2'b01, 2, 0, 1);  cycle("flush");
        drive(1, 2, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);  cycle("postflush");
        drive(1, 0, 0, 0, 0, 6, 1, 2'b00, 0, 0, 0);  cycle("iss6");
        drive(1, 6, 1, 0, 0, 0, 0, 2'b01, 6, 0, 0);  cycle("byp6");
        drive(1, 0, 0, 0, 0, 10, 1, 2'b00, 0, 0, 0); cycle("iss10");

        // Asynchronous reset in the middle of a cycle.
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        err_m = 1'b0;
        chk(sbif.busy_vec, 32'd0, "arst.busy");
        chk(32'(sbif.err_underflow), 32'd0, "arst.err");
        chk(32'(sbif.id_stall), 32'd0, "arst.stall");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            bit [1:0] wbe;
            wbe = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 2) != 0, wbe,
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : pick_pending(),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : pick_pending(),
                  $urandom_range(0, 49) == 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
